// File: rtl/wb_lsu_master.sv
// wb_lsu_master: Wishbone classic initiator for single core load/store requests with lane steering, retry and timeout.
module wb_lsu_master #(
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  output logic        we_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i
);
  typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;
  state_t      state_q, state_d;
  logic [31:0] adr_q, adr_d, wdata_q, wdata_d, rdata_q, rdata_d, rty_q, rty_d, tmo_q, tmo_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic        mis, bus;
  logic [31:0] sh, ld;
  assign mis = (req_size_i == 2'b11) | ((req_size_i == 2'b01) & req_addr_i[0]) |
               ((req_size_i == 2'b10) & (|req_addr_i[1:0]));
  assign sh  = dat_i >> {adr_q[1:0], 3'b000};
  assign ld  = size_q == 2'b00 ? {{24{~uns_q & sh[7]}}, sh[7:0]} :
               size_q == 2'b01 ? {{16{~uns_q & sh[15]}}, sh[15:0]} : sh;
  assign bus = state_q == BUS;
  assign req_ready_o = state_q == IDLE;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign cyc_o = bus;
  assign stb_o = bus;
  assign we_o  = bus & we_q;
  assign adr_o = bus ? {adr_q[31:2], 2'b00} : 32'h0;
  assign sel_o = !bus ? 4'h0 : size_q == 2'b00 ? 4'b0001 << adr_q[1:0] :
                 size_q == 2'b01 ? 4'b0011 << adr_q[1:0] : 4'hf;
  assign dat_o = !bus ? 32'h0 : size_q == 2'b00 ? {4{wdata_q[7:0]}} :
                 size_q == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    rty_d   = rty_q;
    tmo_d   = tmo_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        adr_d   = req_addr_i;
        wdata_d = req_wdata_i;
        size_d  = req_size_i;
        we_d    = req_we_i;
        uns_d   = req_unsigned_i;
        tmo_d   = '0;
        state_d = mis ? RESP : BUS;
        if (mis) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      BUS: begin
        tmo_d = tmo_q + 1;
        // err beats rty beats ack; a late ack still wins over the timeout
        if (err_i || (rty_i && rty_q >= MAX_RETRIES) ||
            (!rty_i && !ack_i && TIMEOUT_CYCLES != 0 && tmo_q == TIMEOUT_CYCLES - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (rty_i) begin
          rty_d   = rty_q + 1;
          state_d = BACKOFF;
        end else if (ack_i) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : ld;
        end
      end
      BACKOFF: begin
        tmo_d   = '0;
        state_d = BUS;
      end
      default: begin
        rty_d   = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      rty_q   <= '0;
      tmo_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      rty_q   <= rty_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_wb_lsu_master.sv
// tb_wb_lsu_master: directed bench with a response scoreboard for wb_lsu_master (MAX_RETRIES=3, TIMEOUT_CYCLES=8).
module tb_wb_lsu_master;
  logic        clk_i = 0, rst_i = 0;
  logic        req_valid_i = 0, req_we_i = 0, req_unsigned_i = 0;
  logic [31:0] req_addr_i = 0, req_wdata_i = 0, dat_i = 0;
  logic [1:0]  req_size_i = 0;
  logic        ack_i = 0, err_i = 0, rty_i = 0;
  logic        req_ready_o, rsp_valid_o, rsp_err_o, cyc_o, stb_o, we_o;
  logic [31:0] rsp_rdata_o, adr_o, dat_o;
  logic [3:0]  sel_o;
  typedef struct {logic err; logic [31:0] rdata;} exp_t;
  exp_t sb[$];
  exp_t m_e;
  int total = 0, bad = 0, n;
  wb_lsu_master #(.MAX_RETRIES(3), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .cyc_o(cyc_o), .stb_o(stb_o),
    .adr_o(adr_o), .sel_o(sel_o), .dat_o(dat_o), .we_o(we_o), .dat_i(dat_i),
    .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i));
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk_i) if (rsp_valid_o === 1'b1) begin
    chk("rsp_pending", 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      m_e = sb.pop_front();
      chk("rsp_err", rsp_err_o, m_e.err);
      chk("rsp_rdata", rsp_rdata_o, m_e.rdata);
    end
  end
  task automatic issue(input logic [31:0] a, input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] wd, input bit push, input logic e_err, input logic [31:0] e_rd);
    for (int i = 0; i < 20 && req_ready_o !== 1'b1; i++) @(negedge clk_i);
    chk("req_ready", req_ready_o, 1);
    req_valid_i = 1; req_addr_i = a; req_we_i = we; req_size_i = sz; req_unsigned_i = u; req_wdata_i = wd;
    if (push) sb.push_back('{e_err, e_rd});
    @(negedge clk_i);
    req_valid_i = 0; req_wdata_i = $urandom; req_addr_i = $urandom;
  endtask
  // k: 0 ack, 1 rty, 2 err, 3 ack+err; responder answers one cycle after stb_o rises
  task automatic attempt(input int k, input logic [31:0] d);
    for (int i = 0; i < 20 && stb_o !== 1'b1; i++) @(negedge clk_i);
    chk("stb_on", stb_o, 1);
    @(negedge clk_i);
    ack_i = (k == 0 || k == 3); rty_i = (k == 1); err_i = (k >= 2); dat_i = d;
    @(negedge clk_i);
    ack_i = 0; rty_i = 0; err_i = 0; dat_i = $urandom;
  endtask
  initial begin
    @(negedge clk_i);
    chk("rst_ready", req_ready_o, 1);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_cyc", cyc_o, 0);
    chk("rst_stb", stb_o, 0);
    chk("rst_adr", adr_o, 0);
    chk("rst_sel", sel_o, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_we", we_o, 0);
    chk("rst_rdata", rsp_rdata_o, 0);
    chk("rst_err", rsp_err_o, 0);
    rst_i = 1;
    @(negedge clk_i);
    issue(32'h100, 0, 2'b10, 0, 0, 1, 0, 32'hDEADBEEF);
    chk("w_adr", adr_o, 32'h100);
    chk("w_sel", sel_o, 4'hf);
    chk("w_we", we_o, 0);
    attempt(0, 32'hDEADBEEF);
    chk("w_cyc_after_ack", cyc_o, 0);
    repeat (2) @(negedge clk_i);
    chk("rsp_hold", rsp_rdata_o, 32'hDEADBEEF);
    issue(32'h103, 0, 2'b00, 0, 0, 1, 0, 32'hFFFFFF80);
    chk("b_sel", sel_o, 4'b1000);
    chk("b_adr", adr_o, 32'h100);
    attempt(0, 32'h80FF0000);
    issue(32'h103, 0, 2'b00, 1, 0, 1, 0, 32'h00000080);
    attempt(0, 32'h80FF0000);
    issue(32'h102, 0, 2'b01, 0, 0, 1, 0, 32'hFFFF8001);
    chk("h_sel", sel_o, 4'b1100);
    attempt(0, 32'h80011234);
    issue(32'h202, 1, 2'b01, 0, 32'h1234ABCD, 1, 0, 0);
    chk("hs_adr", adr_o, 32'h200);
    chk("hs_sel", sel_o, 4'b1100);
    chk("hs_dat", dat_o, 32'hABCDABCD);
    chk("hs_we", we_o, 1);
    attempt(0, 32'hFFFFFFFF);
    issue(32'h101, 1, 2'b00, 0, 32'hAA55, 1, 0, 0);
    chk("bs_sel", sel_o, 4'b0010);
    chk("bs_dat", dat_o, 32'h55555555);
    attempt(0, 32'h12345678);
    issue(32'h201, 0, 2'b01, 0, 0, 1, 1, 0);
    chk("mis_h_cyc", cyc_o, 0);
    @(negedge clk_i);
    chk("mis_h_cyc2", cyc_o, 0);
    issue(32'h0, 0, 2'b11, 0, 0, 1, 1, 0);
    chk("mis_rsvd_cyc", cyc_o, 0);
    issue(32'h102, 0, 2'b10, 0, 0, 1, 1, 0);
    chk("mis_w_cyc", cyc_o, 0);
    issue(32'h300, 0, 2'b10, 0, 0, 1, 1, 0);
    for (int r = 0; r < 3; r++) begin
      attempt(1, 32'h0);
      chk("backoff_stb", stb_o, 0);
      chk("backoff_rsp", rsp_valid_o, 0);
      @(negedge clk_i);
      chk("backoff_len", stb_o, 1);
    end
    attempt(1, 32'h0);
    chk("rty_exhaust_stb", stb_o, 0);
    issue(32'h304, 0, 2'b10, 0, 0, 1, 0, 32'hCAFEF00D);
    attempt(1, 0);
    attempt(1, 0);
    attempt(0, 32'hCAFEF00D);
    issue(32'h308, 0, 2'b10, 0, 0, 1, 0, 32'h0BADF00D);
    for (int r = 0; r < 3; r++) attempt(1, 0);
    attempt(0, 32'h0BADF00D);
    issue(32'h30C, 0, 2'b10, 0, 0, 1, 1, 0);
    attempt(3, 32'h11111111);
    issue(32'h310, 0, 2'b10, 0, 0, 1, 1, 0);
    attempt(2, 32'h22222222);
    issue(32'h400, 0, 2'b10, 0, 0, 1, 1, 0);
    n = 0;
    while (stb_o === 1'b1 && n < 20) begin
      n++;
      @(negedge clk_i);
    end
    chk("tmo_len", n, 8);
    issue(32'h500, 0, 2'b10, 0, 0, 0, 0, 0);
    chk("abort_stb_before", stb_o, 1);
    #2 rst_i = 0;
    #1;
    chk("abort_cyc", cyc_o, 0);
    chk("abort_stb", stb_o, 0);
    chk("abort_ready", req_ready_o, 1);
    repeat (2) @(negedge clk_i);
    rst_i = 1;
    repeat (3) @(negedge clk_i);
    issue(32'h104, 0, 2'b10, 0, 0, 1, 0, 32'h76543210);
    attempt(0, 32'h76543210);
    repeat (3) @(negedge clk_i);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
